// File: rtl/rom_read_arbiter.sv
// Arbiter sharing one synchronous-read ROM port between the VGA fetch path and the processing read path.
// Optional grant statistics outputs are enabled by defining ARB_STATS_EN.
module rom_read_arbiter #(
  parameter int unsigned AW           = 15,
  parameter int unsigned DW           = 8,
  parameter int unsigned ROM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 7
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          VGA_REQ,
  input  logic [AW-1:0] VGA_ADDR,
  output logic          VGA_GNT,
  output logic          VGA_VALID,
  output logic [DW-1:0] VGA_DATA,
  input  logic          PROC_REQ,
  input  logic [AW-1:0] PROC_ADDR,
  output logic          PROC_GNT,
  output logic          PROC_VALID,
  output logic [DW-1:0] PROC_DATA,
  output logic [AW-1:0] ROM_ADDR,
  input  logic [DW-1:0] ROM_Q
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   STAT_VGA_GRANTS,
  output logic [15:0]   STAT_PROC_GRANTS,
  output logic [15:0]   STAT_FORCED
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]   starve_q, starve_nxt;
  logic               force_q, force_nxt;
  logic [AW-1:0]      last_addr;
  logic [ROM_LAT-1:0] tag_vld, tag_own;
  logic               accept;

  // Fixed VGA priority unless the starvation force flag hands the port to PROC.
  always_comb begin
    VGA_GNT    = 1'b0;
    PROC_GNT   = 1'b0;
    ROM_ADDR   = last_addr;
    starve_nxt = '0;
    force_nxt  = 1'b0;
    if (PROC_REQ && (force_q || !VGA_REQ)) begin
      PROC_GNT = 1'b1;
      ROM_ADDR = PROC_ADDR;
    end else if (VGA_REQ) begin
      VGA_GNT  = 1'b1;
      ROM_ADDR = VGA_ADDR;
    end
    if (PROC_REQ && !PROC_GNT) begin
      starve_nxt = (starve_q == CNT_MAX) ? starve_q : starve_q + CNT_W'(1);
      force_nxt  = (starve_nxt >= LIMIT);
    end
  end

  assign accept = VGA_GNT | PROC_GNT;

  // Starvation tracking and last-granted address hold.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      starve_q  <= '0;
      force_q   <= 1'b0;
      last_addr <= '0;
    end else begin
      starve_q <= starve_nxt;
      force_q  <= force_nxt;
      if (accept) last_addr <= ROM_ADDR;
    end
  end

  // Owner tags travel alongside the ROM latency; owner bit set means PROC.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tag_vld    <= '0;
      tag_own    <= '0;
      VGA_VALID  <= 1'b0;
      PROC_VALID <= 1'b0;
      VGA_DATA   <= '0;
      PROC_DATA  <= '0;
    end else begin
      tag_vld[0] <= accept;
      tag_own[0] <= PROC_GNT;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
      VGA_VALID  <= tag_vld[ROM_LAT-1] & ~tag_own[ROM_LAT-1];
      PROC_VALID <= tag_vld[ROM_LAT-1] &  tag_own[ROM_LAT-1];
      if (tag_vld[ROM_LAT-1] && !tag_own[ROM_LAT-1]) VGA_DATA  <= ROM_Q;
      if (tag_vld[ROM_LAT-1] &&  tag_own[ROM_LAT-1]) PROC_DATA <= ROM_Q;
    end
  end

`ifdef ARB_STATS_EN
  localparam int unsigned STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Saturating grant counters; observation only.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      STAT_VGA_GRANTS  <= '0;
      STAT_PROC_GRANTS <= '0;
      STAT_FORCED      <= '0;
    end else begin
      if (VGA_GNT && STAT_VGA_GRANTS != STAT_MAX)
        STAT_VGA_GRANTS <= STAT_VGA_GRANTS + STAT_W'(1);
      if (PROC_GNT && STAT_PROC_GRANTS != STAT_MAX)
        STAT_PROC_GRANTS <= STAT_PROC_GRANTS + STAT_W'(1);
      if (PROC_GNT && force_q && STAT_FORCED != STAT_MAX)
        STAT_FORCED <= STAT_FORCED + STAT_W'(1);
    end
  end
`endif

endmodule
